// File: rtl/uvma_clk_gen_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uvma_clk_gen_pkg                                                   |
// | FSM state encoding and reset phase lengths for uvma_clk_gen.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package uvma_clk_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        DRAIN = 2'd3
    } uvma_clk_gen_state_t;

    localparam int unsigned c_reset_hi_cycles = 1;
    localparam int unsigned c_reset_lo_cycles = 1;

endpackage
`default_nettype wire

// File: rtl/uvma_clk_gen_phase_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uvma_clk_gen_phase_cnt                                             |
// | Phase-length counter; done flags the last cycle of a phase.        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module uvma_clk_gen_phase_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             enable,
    input  logic [CNT_W-1:0] length,
    output logic             done
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // length is never zero here: the top clamps lengths before storing them
    assign done = (r_count == (length - CNT_W'(1)));

endmodule
`default_nettype wire

// File: rtl/uvma_clk_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uvma_clk_gen                                                       |
// | Programmable clock generator with high/low phase lengths and       |
// | period-boundary configuration updates. Define                      |
// | UVMA_CLK_GEN_PERIOD_CNT_EN to build the period_count counter.      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module uvma_clk_gen
    import uvma_clk_gen_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_hi_cycles,
    input  logic [CNT_W-1:0] cfg_lo_cycles,
    output logic             clk_out,
    output logic             running,
    output logic             period_done,
    output logic [31:0]      period_count
);

    uvma_clk_gen_state_t r_state;
    logic                r_clk_out;
    logic                r_running;
    logic                r_period_done;
    logic                r_stop_req;
    logic                r_pending;
    logic [CNT_W-1:0]    r_hi;
    logic [CNT_W-1:0]    r_lo;
    logic [CNT_W-1:0]    r_shadow_hi;
    logic [CNT_W-1:0]    r_shadow_lo;

    logic                w_done;
    logic                w_cnt_load;
    logic                w_cnt_enable;
    logic [CNT_W-1:0]    w_cnt_len;
    logic                w_cfg_fire;
    logic                w_start_go;
    logic                w_low_to_high;

    function automatic logic [CNT_W-1:0] f_eff_len(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    assign w_start_go    = (r_state == IDLE) && start && !stop;
    assign w_low_to_high = (r_state == LOW) && w_done && !stop;
    assign w_cfg_fire    = cfg_valid && !r_pending;
    assign w_cnt_len     = (r_state == HIGH) ? r_hi : r_lo;
    // LOW -> DRAIN keeps counting; every other phase end restarts the counter
    assign w_cnt_load    = w_start_go || ((r_state != IDLE) && w_done);
    assign w_cnt_enable  = (r_state != IDLE);

    uvma_clk_gen_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (w_cnt_load),
        .enable  (w_cnt_enable),
        .length  (w_cnt_len),
        .done    (w_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_clk_out     <= 1'b0;
            r_running     <= 1'b0;
            r_period_done <= 1'b0;
            r_stop_req    <= 1'b0;
        end else begin
            r_period_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start_go) begin
                        r_state       <= HIGH;
                        r_clk_out     <= 1'b1;
                        r_running     <= 1'b1;
                        r_period_done <= 1'b1;
                    end
                end
                HIGH: begin
                    if (stop) begin
                        r_stop_req <= 1'b1;
                    end
                    if (w_done) begin
                        r_clk_out  <= 1'b0;
                        r_stop_req <= 1'b0;
                        r_state    <= (r_stop_req || stop) ? DRAIN : LOW;
                    end
                end
                LOW: begin
                    if (stop) begin
                        if (w_done) begin
                            r_state   <= IDLE;
                            r_running <= 1'b0;
                        end else begin
                            r_state <= DRAIN;
                        end
                    end else if (w_done) begin
                        r_state       <= HIGH;
                        r_clk_out     <= 1'b1;
                        r_period_done <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (w_done) begin
                        r_state   <= IDLE;
                        r_running <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_clk_out <= 1'b0;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    // Active lengths only move at IDLE or on the LOW -> HIGH boundary
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hi        <= CNT_W'(c_reset_hi_cycles);
            r_lo        <= CNT_W'(c_reset_lo_cycles);
            r_shadow_hi <= CNT_W'(c_reset_hi_cycles);
            r_shadow_lo <= CNT_W'(c_reset_lo_cycles);
            r_pending   <= 1'b0;
        end else if (r_state == IDLE) begin
            if (r_pending) begin
                r_hi      <= r_shadow_hi;
                r_lo      <= r_shadow_lo;
                r_pending <= 1'b0;
            end else if (w_cfg_fire) begin
                r_hi <= f_eff_len(cfg_hi_cycles);
                r_lo <= f_eff_len(cfg_lo_cycles);
            end
        end else begin
            if (w_low_to_high && r_pending) begin
                r_hi      <= r_shadow_hi;
                r_lo      <= r_shadow_lo;
                r_pending <= 1'b0;
            end
            if (w_cfg_fire) begin
                r_shadow_hi <= f_eff_len(cfg_hi_cycles);
                r_shadow_lo <= f_eff_len(cfg_lo_cycles);
                r_pending   <= 1'b1;
            end
        end
    end

`ifdef UVMA_CLK_GEN_PERIOD_CNT_EN
    logic [31:0] r_period_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_period_count <= 32'd0;
        end else if (w_start_go || w_low_to_high) begin
            r_period_count <= r_period_count + 32'd1;
        end
    end

    assign period_count = r_period_count;
`else
    assign period_count = 32'd0;
`endif

    assign cfg_ready   = !r_pending;
    assign clk_out     = r_clk_out;
    assign running     = r_running;
    assign period_done = r_period_done;

endmodule
`default_nettype wire

// File: doc/uvma_clk_gen.md
UVMA_CLK_GEN -- requirements
Module: uvma_clk_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of the phase-length counters.
REQ-002 SHALL have port clk, input, 1 bit: the single reference clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit: single-cycle request to begin generating clk_out.
REQ-005 SHALL have port stop, input, 1 bit: single-cycle request to end generation after the current period.
REQ-006 SHALL have ports cfg_valid (input, 1), cfg_ready (output, 1), cfg_hi_cycles (input, CNT_W) and cfg_lo_cycles (input, CNT_W): a valid/ready handshake carrying the high and low phase lengths, in clk cycles.
REQ-007 SHALL have port clk_out, output, 1 bit: the generated clock, driven directly from a flop.
REQ-008 SHALL have port running, output, 1 bit: high whenever the FSM is not IDLE.
REQ-009 SHALL have port period_done, output, 1 bit: a one-cycle pulse in the cycle clk_out rises.
REQ-010 SHALL have port period_count, output, 32 bits: the number of completed periods.

Function
REQ-011 SHALL implement the FSM states IDLE, HIGH, LOW and DRAIN.
- IDLE: clk_out=0.
- HIGH: clk_out=1 for hi_cycles clk cycles.
- LOW: clk_out=0 for lo_cycles clk cycles.
- DRAIN: a LOW phase after which the FSM enters IDLE.
REQ-012 SHALL, on start in IDLE, enter HIGH on the next edge (clk_out=1 one cycle after start) and pulse period_done in that cycle.
REQ-013 SHALL take the transitions HIGH -> LOW and LOW -> HIGH when the phase counter reaches (length-1); the counter is reset to 0 at each phase entry.
REQ-014 SHALL treat a cfg_hi_cycles or cfg_lo_cycles value of 0 as 1.
REQ-015 SHALL give clk_out a period of exactly hi+lo clk cycles with no glitches and no phase shorter than the programmed length.
REQ-016 SHALL handle stop by phase:
- Stop in HIGH: finish HIGH, then run DRAIN for lo_cycles, then enter IDLE.
- Stop in LOW: convert LOW to DRAIN, keeping the counter.
- Stop in IDLE: ignored.
REQ-017 SHALL give stop priority over start when both are asserted in the same cycle; start while not in IDLE is ignored.
REQ-018 SHALL hold the active configuration in active registers and an accepted, not-yet-applied configuration in a shadow register with a pending flag.
REQ-019 SHALL drive cfg_ready = !pending; a handshake occurs when cfg_valid && cfg_ready.
REQ-020 SHALL apply a configuration accepted in IDLE to the active registers on the next edge, without setting pending.
REQ-021 SHALL copy a configuration accepted while running into the active registers on the LOW -> HIGH edge, then clear pending.
REQ-022 SHALL never change the active lengths mid-phase.
REQ-023 SHALL, when a cfg handshake and a LOW -> HIGH transition fall in the same cycle, let the current period use the old values and apply the new values at the following period boundary.
REQ-024 SHALL increment period_count by 1 on each period_done and let it wrap from 0xFFFF_FFFF to 0.
REQ-025 SHALL keep period_count unchanged on stop and clear it only by reset.
REQ-026 SHALL drive period_done only on LOW -> HIGH and IDLE -> HIGH transitions.

Reset
REQ-027 SHALL, while reset_n=0, asynchronously force:
- FSM=IDLE, clk_out=0, running=0, period_done=0, period_count=0.
- pending=0, cfg_ready=1.
- Active hi and lo lengths = 1 each, and phase counter = 0.
REQ-028 SHALL discard a period in progress when reset is asserted mid-period, and stay in IDLE after reset release until a new start.

Configuration
REQ-029 SHALL implement the period counter only when UVMA_CLK_GEN_PERIOD_CNT_EN is defined.
REQ-030 SHALL, without UVMA_CLK_GEN_PERIOD_CNT_EN, tie period_count to 0 and infer no counter flops; all other behaviour is identical.

Structure
REQ-031 SHALL place the FSM state enum uvma_clk_gen_state_t and the default reset lengths in package uvma_clk_gen_pkg.
REQ-032 SHALL place the phase-length counter in one sub-module, uvma_clk_gen_phase_cnt, which takes load, length and enable and produces a done flag.

Verification
REQ-033 SHALL cover: cfg hi=2, lo=3 in IDLE, then start -> clk_out pattern 11000 repeating, period 5, period_done every 5 cycles.
REQ-034 SHALL cover: cfg hi=0, lo=0 -> treated as 1/1, clk_out toggles every cycle, period 2.
REQ-035 SHALL cover:
- Running hi=4, lo=4; new cfg hi=1, lo=1 accepted mid-HIGH.
- Required response: the current period stays 4/4, the next period is 1/1, and cfg_ready is 0 from acceptance until the boundary.
REQ-036 SHALL cover: hi=3, lo=2, stop in the 2nd HIGH cycle -> HIGH completes, 2 LOW cycles, running falls, clk_out stays 0.
REQ-037 SHALL cover: start and stop in the same cycle in IDLE -> no clk_out activity and running stays 0.
REQ-038 SHALL cover:
- Reset asserted mid-HIGH -> clk_out=0 asynchronously and period_count=0.
- With the macro and period_count preloaded near wrap, 0xFFFF_FFFF -> 0 on the next period_done.
